// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the scratch memory arbiter.
// The matrix controller and the SPI bridge import this package as well.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_AW   = 2'd1,
    REQ_HW   = 2'd2,
    REQ_HR   = 2'd3
  } req_e;

  localparam int ARB_ADDR_SIZE    = 10;
  localparam int ARB_WORD_SIZE    = 16;
  localparam int ARB_STARVE_LIMIT = 4;
  localparam logic [ARB_ADDR_SIZE-1:0] ARB_ZERO_ADDR = '1;

endpackage

// File: rtl/arb_starve_cnt.sv
// Per-requester starvation counter. The requester is promoted once it has lost
// STARVE_LIMIT consecutive arbitration cycles.
module arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic valid_i,
  input  logic granted_i,
  input  logic hold_i,
  output logic promoted_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // While the array lock is high, the count is frozen so the lock neither helps nor hurts the host.
  always_comb begin
    cnt_d = cnt_q;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else if (!valid_i || granted_i) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q != LIMIT_C) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign promoted_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/scratch_mem_arbiter.sv
// Single-port scratch RAM arbiter: array writeback, host write and host read,
// with starvation promotion for the host ports and an array burst lock.
module scratch_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_SIZE    = ARB_ADDR_SIZE,
  parameter int WORD_SIZE    = ARB_WORD_SIZE,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
  parameter logic [ADDR_SIZE-1:0] ZERO_ADDR = ARB_ZERO_ADDR
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_SIZE-1:0] aw_addr,
  input  logic [WORD_SIZE-1:0] aw_data,
  input  logic                 a_lock,
  input  logic                 hw_valid,
  output logic                 hw_ready,
  input  logic [ADDR_SIZE-1:0] hw_addr,
  input  logic [WORD_SIZE-1:0] hw_data,
  input  logic                 hr_valid,
  output logic                 hr_ready,
  input  logic [ADDR_SIZE-1:0] hr_addr,
  output logic                 hr_rvalid,
  output logic [WORD_SIZE-1:0] hr_rdata,
  output logic                 m_en,
  output logic                 m_we,
  output logic [ADDR_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 busy
);

  req_e                 grant_s;
  logic                 hw_prom_s, hr_prom_s;
  logic [ADDR_SIZE-1:0] sel_addr_s;
  logic [WORD_SIZE-1:0] sel_data_s;
  logic                 sel_wr_s;
  logic                 sel_zero_s;

  logic                 m_en_q, m_en_d;
  logic                 m_we_q, m_we_d;
  logic [ADDR_SIZE-1:0] m_addr_q, m_addr_d;
  logic [WORD_SIZE-1:0] m_wdata_q, m_wdata_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 rd_zero_q, rd_zero_d;
  logic                 hr_rvalid_q, hr_rvalid_d;
  logic [WORD_SIZE-1:0] hr_rdata_q, hr_rdata_d;
  logic                 busy_q, busy_d;

  arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_hw_starve (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid_i    (hw_valid),
    .granted_i  (grant_s == REQ_HW),
    .hold_i     (a_lock),
    .promoted_o (hw_prom_s)
  );

  arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_hr_starve (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid_i    (hr_valid),
    .granted_i  (grant_s == REQ_HR),
    .hold_i     (a_lock),
    .promoted_o (hr_prom_s)
  );

  // Priority: promoted HW, promoted HR, AW, HW, HR; the lock shuts out both host ports.
  always_comb begin
    grant_s = REQ_NONE;
    if (!a_lock && hw_prom_s && hw_valid) begin
      grant_s = REQ_HW;
    end else if (!a_lock && hr_prom_s && hr_valid) begin
      grant_s = REQ_HR;
    end else if (aw_valid) begin
      grant_s = REQ_AW;
    end else if (!a_lock && hw_valid) begin
      grant_s = REQ_HW;
    end else if (!a_lock && hr_valid) begin
      grant_s = REQ_HR;
    end else begin
      grant_s = REQ_NONE;
    end
  end

  assign aw_ready = reset_n & (grant_s == REQ_AW);
  assign hw_ready = reset_n & (grant_s == REQ_HW);
  assign hr_ready = reset_n & (grant_s == REQ_HR);

  // Mux the winning requester's address and data.
  always_comb begin
    sel_addr_s = {ADDR_SIZE{1'b0}};
    sel_data_s = {WORD_SIZE{1'b0}};
    sel_wr_s   = 1'b0;
    case (grant_s)
      REQ_AW: begin
        sel_addr_s = aw_addr;
        sel_data_s = aw_data;
        sel_wr_s   = 1'b1;
      end
      REQ_HW: begin
        sel_addr_s = hw_addr;
        sel_data_s = hw_data;
        sel_wr_s   = 1'b1;
      end
      REQ_HR: begin
        sel_addr_s = hr_addr;
        sel_data_s = {WORD_SIZE{1'b0}};
        sel_wr_s   = 1'b0;
      end
      default: begin
        sel_addr_s = {ADDR_SIZE{1'b0}};
        sel_data_s = {WORD_SIZE{1'b0}};
        sel_wr_s   = 1'b0;
      end
    endcase
  end

  assign sel_zero_s = (sel_addr_s == ZERO_ADDR);

  // Next state of the RAM port and read return pipeline. Accesses to the zero-point
  // hole never reach the RAM; a hole read returns zero on the normal read timing.
  // m_rdata is sampled during the cycle the read is presented on m_*.
  always_comb begin
    m_en_d      = (grant_s != REQ_NONE) && !sel_zero_s;
    m_we_d      = sel_wr_s && !sel_zero_s;
    m_addr_d    = m_en_d ? sel_addr_s : m_addr_q;
    m_wdata_d   = m_we_d ? sel_data_s : m_wdata_q;
    rd_pend_d   = (grant_s == REQ_HR);
    rd_zero_d   = (grant_s == REQ_HR) && sel_zero_s;
    hr_rvalid_d = rd_pend_q;
    if (rd_pend_q) begin
      hr_rdata_d = rd_zero_q ? {WORD_SIZE{1'b0}} : m_rdata;
    end else begin
      hr_rdata_d = hr_rdata_q;
    end
    busy_d = m_en_d | rd_pend_d;
  end

  // RAM port and read pipeline registers; a read in flight is discarded on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_en_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= {ADDR_SIZE{1'b0}};
      m_wdata_q   <= {WORD_SIZE{1'b0}};
      rd_pend_q   <= 1'b0;
      rd_zero_q   <= 1'b0;
      hr_rvalid_q <= 1'b0;
      hr_rdata_q  <= {WORD_SIZE{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      m_en_q      <= m_en_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      rd_pend_q   <= rd_pend_d;
      rd_zero_q   <= rd_zero_d;
      hr_rvalid_q <= hr_rvalid_d;
      hr_rdata_q  <= hr_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign m_en      = m_en_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign hr_rvalid = hr_rvalid_q;
  assign hr_rdata  = hr_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Bench for scratch_mem_arbiter: directed scenarios plus a random phase, all
// compared against a transaction-level model of the arbitration rules.
module tb_scratch_mem_arbiter;

  localparam int LIM = 4;
  localparam logic [9:0] ZA = 10'h3FF;
  localparam int G_NONE = 0, G_AW = 1, G_HW = 2, G_HR = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        aw_valid, hw_valid, hr_valid, a_lock;
  logic        aw_ready, hw_ready, hr_ready;
  logic [9:0]  aw_addr, hw_addr, hr_addr;
  logic [15:0] aw_data, hw_data;
  logic        hr_rvalid;
  logic [15:0] hr_rdata;
  logic        m_en, m_we;
  logic [9:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        busy;

  int pass_cnt = 0;
  int total    = 0;
  int fail_cnt = 0;

  bit [15:0] ram    [0:1023];
  bit [15:0] shadow [0:1023];

  int          hw_cnt, hr_cnt, last_g;
  logic        exp_en, exp_we, rd1_v, exp_rv, exp_busy;
  logic [9:0]  exp_addr;
  logic [15:0] exp_wdata, rd1_data, exp_rd;
  logic        obs_aw_rdy, obs_hw_rdy, obs_hr_rdy, obs_en, obs_rv;
  logic [15:0] obs_rd;

  always #5 clk = ~clk;

  scratch_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_data(aw_data),
    .a_lock(a_lock),
    .hw_valid(hw_valid), .hw_ready(hw_ready), .hw_addr(hw_addr), .hw_data(hw_data),
    .hr_valid(hr_valid), .hr_ready(hr_ready), .hr_addr(hr_addr),
    .hr_rvalid(hr_rvalid), .hr_rdata(hr_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  // Scratch RAM: synchronous write, read data available while the read is presented.
  always @(posedge clk) begin
    if (m_en && m_we) ram[m_addr] <= m_wdata;
  end
  assign m_rdata = (m_en && !m_we) ? ram[m_addr] : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hw_cnt = 0; hr_cnt = 0; last_g = G_NONE;
    exp_en = 1'b0; exp_we = 1'b0; exp_addr = 10'h000; exp_wdata = 16'h0000;
    rd1_v = 1'b0; rd1_data = 16'h0000; exp_rv = 1'b0; exp_rd = 16'h0000; exp_busy = 1'b0;
  endtask

  // One arbitration cycle: entered at posedge+1 with inputs set, leaves at next posedge+1.
  task automatic cycle();
    int g;
    bit hwp, hrp;
    #2;
    hwp = (hw_cnt == LIM);
    hrp = (hr_cnt == LIM);
    if (!a_lock && hwp && hw_valid)      g = G_HW;
    else if (!a_lock && hrp && hr_valid) g = G_HR;
    else if (aw_valid)                   g = G_AW;
    else if (!a_lock && hw_valid)        g = G_HW;
    else if (!a_lock && hr_valid)        g = G_HR;
    else                                 g = G_NONE;
    obs_aw_rdy = aw_ready; obs_hw_rdy = hw_ready; obs_hr_rdy = hr_ready;
    chk("aw_ready", aw_ready, (g == G_AW) ? 1 : 0);
    chk("hw_ready", hw_ready, (g == G_HW) ? 1 : 0);
    chk("hr_ready", hr_ready, (g == G_HR) ? 1 : 0);
    last_g = g;
    if (!a_lock) begin
      hw_cnt = (!hw_valid || g == G_HW) ? 0 : ((hw_cnt < LIM) ? hw_cnt + 1 : LIM);
      hr_cnt = (!hr_valid || g == G_HR) ? 0 : ((hr_cnt < LIM) ? hr_cnt + 1 : LIM);
    end
    exp_rv = rd1_v;
    if (rd1_v) exp_rd = rd1_data;
    rd1_v = (g == G_HR);
    rd1_data = (hr_addr == ZA) ? 16'h0000 : shadow[hr_addr];
    exp_en = 1'b0; exp_we = 1'b0;
    if (g == G_AW || g == G_HW) begin
      logic [9:0]  a;
      logic [15:0] d;
      a = (g == G_AW) ? aw_addr : hw_addr;
      d = (g == G_AW) ? aw_data : hw_data;
      if (a != ZA) begin
        exp_en = 1'b1; exp_we = 1'b1; exp_addr = a; exp_wdata = d;
        shadow[a] = d;
      end
    end else if (g == G_HR && hr_addr != ZA) begin
      exp_en = 1'b1; exp_addr = hr_addr;
    end
    exp_busy = exp_en | rd1_v;
    @(posedge clk);
    #1;
    obs_en = m_en; obs_rv = hr_rvalid; obs_rd = hr_rdata;
    chk("m_en", m_en, exp_en);
    chk("m_we", m_we, exp_we);
    if (exp_en) chk("m_addr", m_addr, exp_addr);
    if (exp_we) chk("m_wdata", m_wdata, exp_wdata);
    chk("hr_rvalid", hr_rvalid, exp_rv);
    if (exp_rv) chk("hr_rdata", hr_rdata, exp_rd);
    chk("busy", busy, exp_busy);
  endtask

  function automatic logic [9:0] rnd_addr();
    int r;
    r = $urandom_range(0, 15);
    return (r == 15) ? ZA : 10'(r);
  endfunction

  initial begin
    logic [9:0] seq10;
    logic [2:0] seq3;
    logic       lock_rdy;
    int         lock_left;

    reset_n = 1'b0; a_lock = 1'b0;
    aw_valid = 1'b1; hw_valid = 1'b1; hr_valid = 1'b1;
    aw_addr = 10'h000; hw_addr = 10'h000; hr_addr = 10'h000;
    aw_data = 16'h0000; hw_data = 16'h0000;
    #12;
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_hw_ready", hw_ready, 0);
    chk("rst_hr_ready", hr_ready, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_rvalid", hr_rvalid, 0);
    chk("rst_rdata", hr_rdata, 0);
    chk("rst_busy", busy, 0);
    aw_valid = 1'b0; hw_valid = 1'b0; hr_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    model_reset();

    // Reset asserted one cycle after a read grant: the read never returns.
    hr_valid = 1'b1; hr_addr = 10'h005;
    #2 chk("midrd_hr_ready", hr_ready, 1);
    @(posedge clk); #1;
    hr_valid = 1'b0;
    chk("midrd_m_en", m_en, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrd_rst_m_en", m_en, 0);
    chk("midrd_rst_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrd_rvalid", hr_rvalid, 0);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    model_reset();

    // Solo host write.
    hw_valid = 1'b1; hw_addr = 10'h010; hw_data = 16'hBEEF;
    cycle();
    chk("solo_hw_ready", obs_hw_rdy, 1);
    chk("solo_m_en", m_en, 1);
    chk("solo_m_we", m_we, 1);
    chk("solo_m_addr", m_addr, 10'h010);
    chk("solo_m_wdata", m_wdata, 16'hBEEF);
    hw_valid = 1'b0;
    cycle();

    // AW and HW held valid: HW wins every fifth cycle.
    aw_valid = 1'b1; aw_addr = 10'h020; aw_data = 16'hA0A0;
    hw_valid = 1'b1; hw_addr = 10'h030; hw_data = 16'hB0B0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      seq10[i] = obs_hw_rdy;
    end
    chk("starve_pattern", seq10, 10'h210);

    // Two lost cycles, ten locked cycles, then HW must win on the third unlocked cycle.
    cycle(); cycle();
    aw_valid = 1'b0; hr_valid = 1'b1; hr_addr = 10'h007; a_lock = 1'b1;
    lock_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      lock_rdy = lock_rdy | obs_hw_rdy | obs_hr_rdy;
    end
    chk("lock_no_ready", lock_rdy, 0);
    a_lock = 1'b0; hr_valid = 1'b0; aw_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      seq3[i] = obs_hw_rdy;
    end
    chk("lock_hold_cnt", seq3, 3'b100);
    aw_valid = 1'b0; hw_valid = 1'b0;
    cycle();

    // Back-to-back reads after preloading two words.
    hw_valid = 1'b1; hw_addr = 10'h001; hw_data = 16'h1111;
    cycle();
    hw_addr = 10'h002; hw_data = 16'h2222;
    cycle();
    hw_valid = 1'b0;
    cycle();
    hr_valid = 1'b1; hr_addr = 10'h001;
    cycle();
    hr_addr = 10'h002;
    cycle();
    chk("b2b_rv0", obs_rv, 1);
    chk("b2b_rd0", obs_rd, 16'h1111);
    hr_valid = 1'b0;
    cycle();
    chk("b2b_rv1", obs_rv, 1);
    chk("b2b_rd1", obs_rd, 16'h2222);
    cycle();

    // Zero-point hole.
    hw_valid = 1'b1; hw_addr = ZA; hw_data = 16'h1234;
    cycle();
    chk("zero_hw_ready", obs_hw_rdy, 1);
    chk("zero_hw_m_en", obs_en, 0);
    hw_valid = 1'b0; hr_valid = 1'b1; hr_addr = ZA;
    cycle();
    chk("zero_hr_m_en", obs_en, 0);
    hr_valid = 1'b0;
    cycle();
    chk("zero_hr_rv", obs_rv, 1);
    chk("zero_hr_rd", obs_rd, 16'h0000);

    // Random traffic; requesters hold their request until granted.
    lock_left = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(aw_valid && last_g != G_AW)) begin
        aw_valid = ($urandom_range(0, 2) == 0);
        aw_addr = rnd_addr(); aw_data = 16'($urandom);
      end
      if (!(hw_valid && last_g != G_HW)) begin
        hw_valid = ($urandom_range(0, 3) != 0);
        hw_addr = rnd_addr(); hw_data = 16'($urandom);
      end
      if (!(hr_valid && last_g != G_HR)) begin
        hr_valid = ($urandom_range(0, 3) != 0);
        hr_addr = rnd_addr();
      end
      if (lock_left > 0) begin
        lock_left--;
        a_lock = 1'b1;
      end else if ($urandom_range(0, 15) == 0) begin
        lock_left = $urandom_range(0, 5);
        a_lock = 1'b1;
      end else begin
        a_lock = 1'b0;
      end
      cycle();
    end
    aw_valid = 1'b0; hw_valid = 1'b0; hr_valid = 1'b0; a_lock = 1'b0;
    cycle(); cycle(); cycle();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
